// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply and 32/32 divide.
// Each operation takes 32 cycles, then pulses done with the results in hi_out/lo_out.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        done,
    output logic        busy,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] opA_q, opA_d;
    logic [31:0] opB_q, opB_d;
    logic [31:0] workHi_q, workHi_d;
    logic [31:0] workLo_q, workLo_d;
    logic [31:0] hiOut_q, hiOut_d;
    logic [31:0] loOut_q, loOut_d;
    logic        zeroDiv_q, zeroDiv_d;

    logic        negA, negB;
    logic [31:0] magA, magB;
    logic [31:0] absOpA, absOpB;
    logic [32:0] multSum;
    logic [31:0] multHiNext, multLoNext;
    logic [63:0] product, productSigned;
    logic [32:0] divShift, divDiff;
    logic        divGe;
    logic [31:0] divRemNext, divQuoNext;
    logic [31:0] quotientSigned, remainderSigned;

    assign negA   = opA_q[31];
    assign negB   = opB_q[31];
    assign magA   = negA ? -opA_q : opA_q;
    assign magB   = negB ? -opB_q : opB_q;
    assign absOpA = op_a[31] ? -op_a : op_a;
    assign absOpB = op_b[31] ? -op_b : op_b;

    // Shift-and-add: workHi accumulates, workLo shifts the multiplier out and the product low half in.
    assign multSum       = {1'b0, workHi_q} + {1'b0, (workLo_q[0] ? magA : 32'd0)};
    assign multHiNext    = multSum[32:1];
    assign multLoNext    = {multSum[0], workLo_q[31:1]};
    assign product       = {multHiNext, multLoNext};
    assign productSigned = (negA ^ negB) ? -product : product;

    // Restoring division: workHi is the partial remainder, workLo shifts the dividend out and quotient in.
    assign divShift        = {workHi_q, workLo_q[31]};
    assign divGe           = (divShift >= {1'b0, magB});
    assign divDiff         = divShift - {1'b0, magB};
    assign divRemNext      = divGe ? divDiff[31:0] : divShift[31:0];
    assign divQuoNext      = {workLo_q[30:0], divGe};
    assign quotientSigned  = (negA ^ negB) ? -divQuoNext : divQuoNext;
    assign remainderSigned = negA ? -divRemNext : divRemNext;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        workHi_d  = workHi_q;
        workLo_d  = workLo_q;
        hiOut_d   = hiOut_q;
        loOut_d   = loOut_q;
        zeroDiv_d = zeroDiv_q;

        unique case (state_q)
            IDLE: begin
                if (mult_start) begin
                    opA_d     = op_a;
                    opB_d     = op_b;
                    workHi_d  = 32'd0;
                    workLo_d  = absOpB;
                    count_d   = 5'd0;
                    zeroDiv_d = 1'b0;
                    state_d   = MULT;
                end else if (div_start) begin
                    opA_d     = op_a;
                    opB_d     = op_b;
                    workHi_d  = 32'd0;
                    workLo_d  = absOpA;
                    count_d   = 5'd0;
                    zeroDiv_d = (op_b == 32'd0);
                    state_d   = DIV;
                end
            end
            MULT: begin
                workHi_d = multHiNext;
                workLo_d = multLoNext;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    hiOut_d = productSigned[63:32];
                    loOut_d = productSigned[31:0];
                    state_d = DONE;
                end
            end
            DIV: begin
                workHi_d = divRemNext;
                workLo_d = divQuoNext;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    if (zeroDiv_q) begin
                        hiOut_d = opA_q;
                        loOut_d = 32'hFFFF_FFFF;
                    end else begin
                        hiOut_d = remainderSigned;
                        loOut_d = quotientSigned;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            opA_q     <= 32'd0;
            opB_q     <= 32'd0;
            workHi_q  <= 32'd0;
            workLo_q  <= 32'd0;
            hiOut_q   <= 32'd0;
            loOut_q   <= 32'd0;
            zeroDiv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            workHi_q  <= workHi_d;
            workLo_q  <= workLo_d;
            hiOut_q   <= hiOut_d;
            loOut_q   <= loOut_d;
            zeroDiv_q <= zeroDiv_d;
        end
    end

    // Status outputs decode the state register only, so the consumer can latch results on done safely.
    assign hi_out   = hiOut_q;
    assign lo_out   = loOut_q;
    assign done     = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign div_zero = (state_q == DONE) && zeroDiv_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed multiply/divide results, latency,
// busy/done/div_zero timing, start arbitration and asynchronous reset abort.
module tb_mult_div_unit;

    logic        clk;
    logic        reset_n;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;
    logic        busy;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    mult_div_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .done       (done),
        .busy       (busy),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds a start for one rising edge, then scrambles the operands to catch late sampling.
    task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mult_start = m;
        div_start  = d;
        op_a       = a;
        op_b       = b;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = 32'hDEAD_BEEF;
        op_b       = 32'hCAFE_F00D;
    endtask

    task automatic waitDone(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = busy ? 1 : 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (busy) busyCycles++;
        end
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hi_out, lo_out, done, busy, div_zero} !== 67'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got hi=%h lo=%h done=%b busy=%b dz=%b, expected all zero",
                     hi_out, lo_out, done, busy, div_zero);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_mult_basic;
        int n, b;
        pulse(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        waitDone(n, b);
        checks++;
        if (n !== 32) begin failures++; $display("[TB] FAIL mult_latency: got %0d expected 32", n); end
        checks++;
        if (b !== 33) begin failures++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 33", b); end
        checks++;
        if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_7x-3_hi: got %h expected FFFFFFFF", hi_out); end
        checks++;
        if (lo_out !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mult_7x-3_lo: got %h expected FFFFFFEB", lo_out); end
        checks++;
        if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL mult_div_zero: got %b expected 0", div_zero); end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin failures++; $display("[TB] FAIL mult_done_one_cycle: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_mult_max;
        int n, b;
        pulse(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        waitDone(n, b);
        checks++;
        if ({hi_out, lo_out} !== 64'h3FFF_FFFF_0000_0001) begin
            failures++;
            $display("[TB] FAIL mult_max: got %h_%h expected 3FFFFFFF_00000001", hi_out, lo_out);
        end
    endtask

    task automatic test_div_signed;
        int n, b;
        pulse(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        waitDone(n, b);
        checks++;
        if (n !== 32) begin failures++; $display("[TB] FAIL div_latency: got %0d expected 32", n); end
        checks++;
        if (lo_out !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_-7/2_quotient: got %h expected FFFFFFFD", lo_out); end
        checks++;
        if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_-7/2_remainder: got %h expected FFFFFFFF", hi_out); end
        checks++;
        if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL div_-7/2_div_zero: got %b expected 0", div_zero); end
        repeat (3) @(negedge clk);
        checks++;
        if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            failures++;
            $display("[TB] FAIL div_result_hold: got %h_%h expected FFFFFFFF_FFFFFFFD", hi_out, lo_out);
        end
    endtask

    task automatic test_div_zero;
        int n, b;
        pulse(1'b0, 1'b1, 32'd5, 32'd0);
        waitDone(n, b);
        checks++;
        if (n !== 32) begin failures++; $display("[TB] FAIL divzero_latency: got %0d expected 32", n); end
        checks++;
        if (hi_out !== 32'd5) begin failures++; $display("[TB] FAIL divzero_hi: got %h expected 00000005", hi_out); end
        checks++;
        if (lo_out !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divzero_lo: got %h expected FFFFFFFF", lo_out); end
        checks++;
        if (div_zero !== 1'b1) begin failures++; $display("[TB] FAIL divzero_flag: got %b expected 1", div_zero); end
        @(negedge clk);
        checks++;
        if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL divzero_one_cycle: got %b expected 0", div_zero); end
    endtask

    task automatic test_back_to_back;
        int n, b;
        pulse(1'b0, 1'b1, 32'd100, 32'd7);
        waitDone(n, b);
        checks++;
        if ({hi_out, lo_out} !== {32'd2, 32'd14}) begin
            failures++;
            $display("[TB] FAIL div_100/7: got %h_%h expected 00000002_0000000E", hi_out, lo_out);
        end
        div_start = 1'b1;
        op_a      = 32'h8000_0000;
        op_b      = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL start_ignored_in_done: got busy=%b expected 0", busy); end
        @(negedge clk);
        div_start = 1'b0;
        op_a      = 32'd1;
        op_b      = 32'd1;
        waitDone(n, b);
        checks++;
        if (n !== 32) begin failures++; $display("[TB] FAIL back_to_back_latency: got %0d expected 32", n); end
        checks++;
        if ({hi_out, lo_out, div_zero} !== {32'd0, 32'h8000_0000, 1'b0}) begin
            failures++;
            $display("[TB] FAIL div_overflow: got hi=%h lo=%h dz=%b expected 00000000 80000000 0", hi_out, lo_out, div_zero);
        end
    endtask

    task automatic test_both_start;
        int doneCount, doneAt;
        logic [31:0] hiSeen, loSeen;
        logic zSeen;
        doneCount = 0;
        doneAt    = 0;
        hiSeen    = 32'hX;
        loSeen    = 32'hX;
        zSeen     = 1'bX;
        pulse(1'b1, 1'b1, 32'd6, 32'd3);
        for (int i = 1; i <= 45; i++) begin
            div_start = (i == 10);
            if (i == 10) begin
                op_a = 32'd1000;
                op_b = 32'd10;
            end
            @(negedge clk);
            if (done) begin
                doneCount++;
                doneAt = i;
                hiSeen = hi_out;
                loSeen = lo_out;
                zSeen  = div_zero;
            end
        end
        div_start = 1'b0;
        checks++;
        if (doneCount !== 1) begin failures++; $display("[TB] FAIL both_start_done_count: got %0d expected 1", doneCount); end
        checks++;
        if (doneAt !== 32) begin failures++; $display("[TB] FAIL both_start_latency: got %0d expected 32", doneAt); end
        checks++;
        if ({hiSeen, loSeen, zSeen} !== {32'd0, 32'd18, 1'b0}) begin
            failures++;
            $display("[TB] FAIL both_start_result: got hi=%h lo=%h dz=%b expected 00000000 00000012 0", hiSeen, loSeen, zSeen);
        end
    endtask

    task automatic test_reset_abort;
        int n, b, doneCount;
        pulse(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (15) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({hi_out, lo_out, done, busy, div_zero} !== 67'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_abort: got hi=%h lo=%h done=%b busy=%b dz=%b expected all zero",
                     hi_out, lo_out, done, busy, div_zero);
        end
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        doneCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checks++;
        if (doneCount !== 0) begin failures++; $display("[TB] FAIL no_done_after_abort: got %0d expected 0", doneCount); end
        pulse(1'b1, 1'b0, 32'd2, 32'd3);
        waitDone(n, b);
        checks++;
        if ({n, hi_out, lo_out} !== {32'd32, 32'd0, 32'd6}) begin
            failures++;
            $display("[TB] FAIL mult_after_reset: got latency=%0d hi=%h lo=%h expected 32 00000000 00000006", n, hi_out, lo_out);
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_mult_max();
        test_div_signed();
        test_div_zero();
        test_back_to_back();
        test_both_start();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; port names SHALL follow the codebase (clk, reset_n).
REQ-002 The ports SHALL be as follows (clock and reset first):
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mult_start  in  1  one-cycle request for a signed multiply of op_a by op_b.
- div_start  in  1  one-cycle request for a signed divide of op_a by op_b.
- op_a  in  32  operand A (multiplicand or dividend).
- op_b  in  32  operand B (multiplier or divisor).
- hi_out  out  32  multiply: product[63:32]; divide: remainder.
- lo_out  out  32  multiply: product[31:0]; divide: quotient.
- done  out  1  one-cycle pulse; hi_out and lo_out are valid in the same cycle.
- busy  out  1  high from the accepted start until done, inclusive.
- div_zero  out  1  high with done when the completed divide had op_b == 0.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, MULT, DIV, DONE.
REQ-004 In IDLE, a rising edge with mult_start=1 SHALL capture op_a and op_b and move to MULT.
REQ-005 In IDLE, a rising edge with div_start=1 and mult_start=0 SHALL capture op_a and op_b and move to DIV.
REQ-006 If mult_start and div_start are both high in IDLE, the multiply SHALL win; the divide request is dropped.
REQ-007 mult_start and div_start SHALL be ignored in MULT, DIV and DONE; no queuing.
REQ-008 Operands SHALL be sampled only on the accepting edge; later changes to op_a and op_b SHALL NOT affect the result.
REQ-009 MULT SHALL operate as follows:
- take the magnitudes of both operands;
- perform 32 iterations of unsigned shift-and-add, one per cycle, using a 5-bit iteration counter (0..31);
- negate the 64-bit product if the operand signs differ.
REQ-010 DIV SHALL operate as follows:
- take the magnitudes of both operands;
- perform 32 iterations of unsigned restoring division, one per cycle;
- negate the quotient if the operand signs differ;
- give the remainder the sign of op_a, so the quotient truncates toward zero.
REQ-011 On the edge where the counter reaches 31, the FSM SHALL enter DONE, with the sign-corrected results registered into hi_out and lo_out on that same edge.
REQ-012 Latency: done SHALL be high in the cycle following the 32nd edge after the accepting edge, for exactly one cycle.
REQ-013 On the edge after DONE, the FSM SHALL return to IDLE; a start is accepted from that IDLE cycle onward.
REQ-014 hi_out and lo_out SHALL hold their values from DONE until the next DONE or reset.
REQ-015 Divide by zero (op_b == 0) SHALL still take the full 32-cycle latency, and then give:
- hi_out = op_a;
- lo_out = 32'hFFFFFFFF;
- div_zero = 1 with done.
REQ-016 div_zero SHALL be 0 whenever done is 0, and 0 with done for a multiply.
REQ-017 The overflow case 0x80000000 / 0xFFFFFFFF SHALL give lo_out = 0x80000000, hi_out = 0, div_zero = 0.
REQ-018 busy SHALL be 1 in MULT, DIV and DONE, and 0 in IDLE.
REQ-019 The control unit captures HI/LO combinationally on done in its wait state; done SHALL therefore be driven from the state register only, with no combinational path from the inputs.

Reset
REQ-020 While reset_n = 0, regardless of clk, the block SHALL force:
- state = IDLE and counter = 0;
- hi_out = 0, lo_out = 0;
- done = 0, busy = 0, div_zero = 0.
REQ-021 Reset asserted mid-operation SHALL abort it immediately; no done pulse SHALL follow.
REQ-022 After reset_n rises, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- mult_start, op_a=7, op_b=-3 -> done 32 cycles later; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high for 33 cycles.
- mult_start, op_a=0x7FFFFFFF, op_b=0x7FFFFFFF -> hi_out=0x3FFFFFFF, lo_out=0x00000001.
- div_start, op_a=-7, op_b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1), div_zero=0.
- div_start, op_a=5, op_b=0 -> done after 32 cycles; hi_out=5, lo_out=0xFFFFFFFF, div_zero=1 for one cycle only.
- mult_start and div_start together, op_a=6, op_b=3; then div_start pulsed at cycle 10 -> multiply result only (lo_out=18, hi_out=0); exactly one done.
- reset_n pulsed low at cycle 15 of a divide -> all outputs 0 asynchronously; no done; a new mult_start 2, 3 afterwards gives lo_out=6.
